// File: rtl/ptb_pkg.sv
// ============================================================================
//  ptb_pkg
//  Shared types and constants for the pretrigger-buffer capture controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ptb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } ptb_state_t;

    // The pretrigger buffer never delivers fewer than this many pre-samples.
    localparam int PTB_MIN_PRE = 3;

    localparam int PTB_DATA_WIDTH      = 28;
    localparam int PTB_PRE_CONF_WIDTH  = 6;
    localparam int PTB_POST_CONF_WIDTH = 8;
    localparam int PTB_HOLDOFF_WIDTH   = 8;
    localparam int PTB_LOST_CNT_WIDTH  = 16;
    localparam int PTB_LTC_WIDTH       = 48;

    // Optional header word: ltc[PTB_HDR_LTC_LSB +: data width].
    localparam int PTB_HDR_LTC_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/ptb_capture_ctrl_sat_counter.sv
// ============================================================================
//  sat_counter
//  Up-counter that sticks at all-ones; cleared only by reset.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ptb_capture_ctrl.sv
// ============================================================================
//  ptb_capture_ctrl
//  Trigger-driven record sequencer feeding the event FIFO from the pretrigger
//  buffer. Optional header word enabled by macro PTB_CAPTURE_HEADER_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ptb_capture_ctrl
    import ptb_pkg::*;
#(
    parameter int P_DATA_WIDTH      = PTB_DATA_WIDTH,
    parameter int P_PRE_CONF_WIDTH  = PTB_PRE_CONF_WIDTH,
    parameter int P_POST_CONF_WIDTH = PTB_POST_CONF_WIDTH,
    parameter int P_HOLDOFF_WIDTH   = PTB_HOLDOFF_WIDTH,
    parameter int P_LOST_CNT_WIDTH  = PTB_LOST_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ptb_rdy,
    input  logic [P_DATA_WIDTH-1:0]      ptb_data,
    input  logic                         trig,
    input  logic                         arm,
    input  logic                         fifo_afull,
    input  logic [P_PRE_CONF_WIDTH-1:0]  pre_conf,
    input  logic [P_POST_CONF_WIDTH-1:0] post_conf,
    input  logic [P_HOLDOFF_WIDTH-1:0]   holdoff_conf,
    input  logic [PTB_LTC_WIDTH-1:0]     ltc,
    output logic                         out_valid,
    output logic [P_DATA_WIDTH-1:0]      out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic [P_LOST_CNT_WIDTH-1:0]  lost_trig
);

    localparam int LW = P_PRE_CONF_WIDTH + P_POST_CONF_WIDTH + 1;

    ptb_state_t                 r_state;
    logic [LW-1:0]              r_remain;
    logic [P_HOLDOFF_WIDTH-1:0] r_hold;

    logic [P_PRE_CONF_WIDTH-1:0] w_pre_eff;
    logic [LW-1:0]               w_rec_words;
    logic [P_DATA_WIDTH-1:0]     w_first_word;
    logic [P_DATA_WIDTH-1:0]     w_sample;
    logic                        w_accept;
    logic                        w_lost_inc;
    logic                        w_unused_ltc;

`ifdef PTB_CAPTURE_HEADER_EN
    localparam logic [LW-1:0] c_hdr_words = LW'(1);

    // One extra delay stage keeps samples aligned behind the header word.
    logic [P_DATA_WIDTH-1:0] r_ptb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptb_d <= '0;
        end else begin
            r_ptb_d <= ptb_data;
        end
    end

    assign w_first_word = ltc[PTB_HDR_LTC_LSB +: P_DATA_WIDTH];
    assign w_sample     = r_ptb_d;
`else
    localparam logic [LW-1:0] c_hdr_words = LW'(0);

    assign w_first_word = ptb_data;
    assign w_sample     = ptb_data;
`endif

    assign w_unused_ltc = ^ltc;

    assign w_pre_eff   = (pre_conf < P_PRE_CONF_WIDTH'(PTB_MIN_PRE))
                       ? P_PRE_CONF_WIDTH'(PTB_MIN_PRE) : pre_conf;
    assign w_rec_words = LW'(w_pre_eff) + LW'(post_conf) + c_hdr_words;

    assign w_accept   = (r_state == ST_ARMED) && arm && trig && !fifo_afull;
    assign w_lost_inc = trig && (r_state != ST_IDLE) && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_remain  <= '0;
            r_hold    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arm && ptb_rdy) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!arm) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_state   <= ST_CAPTURE;
                        out_valid <= 1'b1;
                        out_data  <= w_first_word;
                        out_last  <= (w_rec_words == LW'(1));
                        r_remain  <= w_rec_words - LW'(1);
                        busy      <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // r_remain counts words still owed after the one on the output.
                    if (r_remain != '0) begin
                        out_valid <= 1'b1;
                        out_data  <= w_sample;
                        out_last  <= (r_remain == LW'(1));
                        r_remain  <= r_remain - LW'(1);
                    end else begin
                        r_state <= ST_HOLDOFF;
                        r_hold  <= holdoff_conf;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_hold <= P_HOLDOFF_WIDTH'(1)) begin
                        busy    <= 1'b0;
                        r_state <= (arm && ptb_rdy) ? ST_ARMED : ST_IDLE;
                    end else begin
                        r_hold <= r_hold - P_HOLDOFF_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (P_LOST_CNT_WIDTH)
    ) u_lost_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_lost_inc),
        .count (lost_trig)
    );

endmodule

`default_nettype wire
